// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
//   OPC_LOAD / OPC_STORE : major opcodes that route through the data cache
//   load_funct3_e        : load width/extension selectors (LB..LWU)
//   store_funct3_e       : store width selectors (SB..SD)
//   mem_state_e          : stage FSM states
//   control_signals_struct : control bundle carried from execute to writeback
package mem_stage_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LD  = 3'b011,
    LBU = 3'b100,
    LHU = 3'b101,
    LWU = 3'b110
  } load_funct3_e;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010,
    SD = 3'b011
  } store_funct3_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_state_e;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [31:0] instruction;
    logic        jump_signal;
    logic        reg_write;
    logic        mem_to_reg;
  } control_signals_struct;

  // Byte-enable pattern for an access of the given size, anchored at lane 0.
  function automatic logic [7:0] store_base_strobe(input logic [1:0] size);
    logic [7:0] strb;
    case (store_funct3_e'({1'b0, size}))
      SB:      strb = 8'h01;
      SH:      strb = 8'h03;
      SW:      strb = 8'h0F;
      default: strb = 8'hFF;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational byte-lane alignment for the MEM stage.
//   is_load/is_store : access kind
//   funct3           : width/extension selector
//   lane             : byte offset within the 8-byte word (addr[2:0])
//   store_data       : rs2 value, shifted into lane position -> wdata
//   wstrb            : byte strobes, lanes past 7 are dropped
//   load_raw         : raw cache word, shifted down and extended -> load_data
//   illegal          : funct3 not valid for this access kind
//   misalign_trap    : access is not size-aligned; only asserted when
//                      MEM_MISALIGN_TRAP_EN is defined, otherwise tied 0
module load_store_align
  import mem_stage_pkg::*;
(
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [2:0]  lane,
  input  logic [63:0] store_data,
  input  logic [63:0] load_raw,
  output logic [63:0] wdata,
  output logic [7:0]  wstrb,
  output logic [63:0] load_data,
  output logic        illegal,
  output logic        misalign_trap
);

  logic [5:0]  bit_shift;
  logic [63:0] shifted;

  always_comb begin
    bit_shift = {lane, 3'b000};
    wdata     = store_data << bit_shift;
    wstrb     = store_base_strobe(funct3[1:0]) << lane;
    shifted   = load_raw >> bit_shift;
    case (load_funct3_e'(funct3))
      LB:      load_data = {{56{shifted[7]}},  shifted[7:0]};
      LH:      load_data = {{48{shifted[15]}}, shifted[15:0]};
      LW:      load_data = {{32{shifted[31]}}, shifted[31:0]};
      LD:      load_data = shifted;
      LBU:     load_data = {56'd0, shifted[7:0]};
      LHU:     load_data = {48'd0, shifted[15:0]};
      LWU:     load_data = {32'd0, shifted[31:0]};
      default: load_data = '0;
    endcase
    illegal = (is_load && (funct3 == 3'b111)) || (is_store && funct3[2]);
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // A size-aligned access can never straddle the 8-byte boundary, so the
  // alignment test also covers the boundary-crossing case.
  logic misaligned;

  always_comb begin
    case (funct3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = lane[0];
      2'b10:   misaligned = |lane[1:0];
      default: misaligned = |lane;
    endcase
    misalign_trap = (is_load || is_store) && misaligned;
  end
`else
  assign misalign_trap = 1'b0;
`endif

endmodule

// File: rtl/memory_access_stage.sv
// Pipeline MEM stage between execute and writeback.
// Captures the ALU result, rs2 and control bundle when memory_enable is seen,
// runs loads/stores through a request/response handshake to the data cache,
// and presents results to writeback with memory_done until memory_enable drops.
// Ports:
//   clk, reset (async, active-low)
//   alu_data_in, reg_b_contents, control_signals, memory_enable : from execute
//   dcache_req_valid/ready, dcache_addr/we/wdata/wstrb            : cache request
//   dcache_resp_valid, dcache_rdata                                : cache response
//   mem_data_out, alu_data_out, control_signals_out, memory_done   : to writeback
//   mem_fault : misaligned access trapped (MEM_MISALIGN_TRAP_EN builds only)
// Optional feature macro: MEM_MISALIGN_TRAP_EN
module memory_access_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [63:0]             alu_data_in,
  input  logic [63:0]             reg_b_contents,
  input  control_signals_struct   control_signals,
  input  logic                    memory_enable,
  output logic                    dcache_req_valid,
  input  logic                    dcache_req_ready,
  output logic [ADDR_WIDTH-1:0]   dcache_addr,
  output logic                    dcache_we,
  output logic [DATA_WIDTH-1:0]   dcache_wdata,
  output logic [DATA_WIDTH/8-1:0] dcache_wstrb,
  input  logic                    dcache_resp_valid,
  input  logic [DATA_WIDTH-1:0]   dcache_rdata,
  output logic [DATA_WIDTH-1:0]   mem_data_out,
  output logic [63:0]             alu_data_out,
  output control_signals_struct   control_signals_out,
  output logic                    memory_done,
  output logic                    mem_fault
);

  mem_state_e                state_q, state_d;
  logic                      req_valid_q, req_valid_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic                      we_q, we_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0]     mem_data_q, mem_data_d;
  logic [63:0]               alu_q, alu_d;
  control_signals_struct     ctrl_q, ctrl_d;
  logic                      done_q, done_d;
  logic                      fault_q, fault_d;

  // In IDLE the align unit decodes the incoming instruction to decide on
  // issue; afterwards it decodes the captured one so the load extension
  // in WAIT uses the latched funct3 and lane.
  logic [6:0]  sel_opcode;
  logic [2:0]  sel_funct3;
  logic [2:0]  sel_lane;
  logic        is_load, is_store, is_mem;
  logic [63:0] al_wdata, al_load_data;
  logic [7:0]  al_wstrb;
  logic        al_illegal, al_trap;

  always_comb begin
    if (state_q == IDLE) begin
      sel_opcode = control_signals.opcode;
      sel_funct3 = control_signals.instruction[14:12];
      sel_lane   = alu_data_in[2:0];
    end else begin
      sel_opcode = ctrl_q.opcode;
      sel_funct3 = ctrl_q.instruction[14:12];
      sel_lane   = alu_q[2:0];
    end
    is_load  = (sel_opcode == OPC_LOAD);
    is_store = (sel_opcode == OPC_STORE);
    is_mem   = is_load || is_store;
  end

  load_store_align u_align (
    .is_load       (is_load),
    .is_store      (is_store),
    .funct3        (sel_funct3),
    .lane          (sel_lane),
    .store_data    (reg_b_contents),
    .load_raw      (dcache_rdata),
    .wdata         (al_wdata),
    .wstrb         (al_wstrb),
    .load_data     (al_load_data),
    .illegal       (al_illegal),
    .misalign_trap (al_trap)
  );

  always_comb begin
    state_d     = state_q;
    req_valid_d = req_valid_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    mem_data_d  = mem_data_q;
    alu_d       = alu_q;
    ctrl_d      = ctrl_q;
    done_d      = done_q;
    fault_d     = fault_q;
    case (state_q)
      IDLE: begin
        if (memory_enable) begin
          alu_d      = alu_data_in;
          ctrl_d     = control_signals;
          mem_data_d = '0;
          fault_d    = 1'b0;
          if (is_mem && !al_illegal && !al_trap) begin
            req_valid_d = 1'b1;
            addr_d      = alu_data_in[ADDR_WIDTH-1:0];
            we_d        = is_store;
            wdata_d     = is_store ? al_wdata : '0;
            wstrb_d     = is_store ? al_wstrb : '0;
            state_d     = REQ;
          end else begin
            fault_d = is_mem && !al_illegal && al_trap;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      REQ: begin
        if (dcache_req_ready) begin
          req_valid_d = 1'b0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (dcache_resp_valid) begin
          mem_data_d = is_load ? al_load_data : '0;
          done_d     = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (!memory_enable) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      req_valid_q <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      mem_data_q  <= '0;
      alu_q       <= '0;
      ctrl_q      <= '0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      mem_data_q  <= mem_data_d;
      alu_q       <= alu_d;
      ctrl_q      <= ctrl_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
    end
  end

  assign dcache_req_valid    = req_valid_q;
  assign dcache_addr         = addr_q;
  assign dcache_we           = we_q;
  assign dcache_wdata        = wdata_q;
  assign dcache_wstrb        = wstrb_q;
  assign mem_data_out        = mem_data_q;
  assign alu_data_out        = alu_q;
  assign control_signals_out = ctrl_q;
  assign memory_done         = done_q;
  assign mem_fault           = fault_q;

endmodule

// File: tb/tb_memory_access_stage.sv
module tb_memory_access_stage;
  import mem_stage_pkg::*;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_ALU = 7'b0010011;

  logic                  clk;
  logic                  reset;
  logic [63:0]           alu_data_in;
  logic [63:0]           reg_b_contents;
  control_signals_struct control_signals;
  logic                  memory_enable;
  logic                  dcache_req_valid;
  logic                  dcache_req_ready;
  logic [63:0]           dcache_addr;
  logic                  dcache_we;
  logic [63:0]           dcache_wdata;
  logic [7:0]            dcache_wstrb;
  logic                  dcache_resp_valid;
  logic [63:0]           dcache_rdata;
  logic [63:0]           mem_data_out;
  logic [63:0]           alu_data_out;
  control_signals_struct control_signals_out;
  logic                  memory_done;
  logic                  mem_fault;

  memory_access_stage #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
    .clk                 (clk),
    .reset               (reset),
    .alu_data_in         (alu_data_in),
    .reg_b_contents      (reg_b_contents),
    .control_signals     (control_signals),
    .memory_enable       (memory_enable),
    .dcache_req_valid    (dcache_req_valid),
    .dcache_req_ready    (dcache_req_ready),
    .dcache_addr         (dcache_addr),
    .dcache_we           (dcache_we),
    .dcache_wdata        (dcache_wdata),
    .dcache_wstrb        (dcache_wstrb),
    .dcache_resp_valid   (dcache_resp_valid),
    .dcache_rdata        (dcache_rdata),
    .mem_data_out        (mem_data_out),
    .alu_data_out        (alu_data_out),
    .control_signals_out (control_signals_out),
    .memory_done         (memory_done),
    .mem_fault           (mem_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  typedef struct {
    bit          req;
    logic        we;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [63:0] mem;
    logic        fault;
  } exp_t;

  typedef struct {
    bit                    got_done;
    int unsigned           cycles;
    bit                    saw_req;
    logic [63:0]           addr;
    logic                  we;
    logic [63:0]           wdata;
    logic [7:0]            wstrb;
    bit                    stable;
    bit                    order;
    logic [63:0]           mem;
    logic [63:0]           alu;
    control_signals_struct ctrl;
    logic                  fault;
    bit                    held;
    bit                    drop;
  } res_t;

  typedef struct {
    string       nm;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] rd;
    int unsigned rdy;
    int unsigned rsp;
    exp_t        e;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
    end
  endtask

  function automatic control_signals_struct mk_ctrl(input logic [6:0] op, input logic [2:0] f3);
    control_signals_struct c;
    c.instruction        = $urandom();
    c.instruction[6:0]   = op;
    c.instruction[14:12] = f3;
    c.opcode             = op;
    c.jump_signal        = 1'($urandom_range(0, 1));
    c.reg_write          = 1'($urandom_range(0, 1));
    c.mem_to_reg         = 1'($urandom_range(0, 1));
    return c;
  endfunction

  function automatic exp_t mk_exp(input bit req, input logic we, input logic [63:0] wdata,
                                  input logic [7:0] wstrb, input logic [63:0] mem, input logic fault);
    exp_t e;
    e.req = req; e.we = we; e.wdata = wdata; e.wstrb = wstrb; e.mem = mem; e.fault = fault;
    return e;
  endfunction

  // Reference: byte-by-byte view of the access as the cache sees it.
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3_in,
                                 input logic [63:0] a, input logic [63:0] b, input logic [63:0] rd);
    exp_t        e;
    int unsigned f3, lane, sz;
    bit          ld, st, legal;
    logic [63:0] val;
    e    = mk_exp(0, 1'b0, '0, '0, '0, 1'b0);
    f3   = f3_in;
    lane = a % 8;
    sz   = 1 << (f3 % 4);
    ld   = (op == OP_LD);
    st   = (op == OP_ST);
    legal = ld ? (f3 != 7) : (st ? (f3 < 4) : 1'b0);
    if (!legal) return e;
    if (TRAP && ((a % 64'(sz)) != 0)) begin
      e.fault = 1'b1;
      return e;
    end
    e.req = 1'b1;
    e.we  = st;
    if (st) begin
      for (int unsigned j = 0; j < 8; j++)
        if (lane + j < 8) e.wdata[8*(lane+j) +: 8] = b[8*j +: 8];
      for (int unsigned j = 0; j < sz; j++)
        if (lane + j < 8) e.wstrb[lane+j] = 1'b1;
    end else begin
      val = '0;
      for (int unsigned j = 0; j < sz; j++)
        if (lane + j < 8) val[8*j +: 8] = rd[8*(lane+j) +: 8];
      if (f3 < 3 && val[8*sz-1])
        for (int unsigned k = 8*sz; k < 64; k++) val[k] = 1'b1;
      e.mem = val;
    end
    return e;
  endfunction

  // Drives one instruction and acts as the data cache: ready after rdy
  // cycles of request, response rsp cycles after acceptance.
  task automatic do_txn(input control_signals_struct c, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] rd, input int unsigned rdy, input int unsigned rsp,
                        output res_t r);
    int unsigned phase, cnt, cyc;
    r.got_done = 0; r.cycles = 0; r.saw_req = 0; r.addr = '0; r.we = 1'b0; r.wdata = '0;
    r.wstrb = '0; r.stable = 1; r.order = 1; r.mem = '0; r.alu = '0; r.ctrl = '0;
    r.fault = 1'b0; r.held = 0; r.drop = 0;
    control_signals   = c;
    alu_data_in       = a;
    reg_b_contents    = b;
    memory_enable     = 1'b1;
    dcache_req_ready  = 1'b0;
    dcache_resp_valid = 1'b0;
    dcache_rdata      = {$urandom(), $urandom()};
    phase = 0; cnt = 0; cyc = 0;
    while (!r.got_done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (phase == 1 && dcache_req_ready) begin
        phase = 2; cnt = 0; dcache_req_ready = 1'b0;
      end else if (phase == 2 && dcache_resp_valid) begin
        phase = 3; dcache_resp_valid = 1'b0; dcache_rdata = {$urandom(), $urandom()};
      end
      if (memory_done) begin
        r.got_done = 1;
        r.cycles   = cyc;
        if (phase == 1 || phase == 2) r.order = 0;
        r.mem   = mem_data_out;
        r.alu   = alu_data_out;
        r.ctrl  = control_signals_out;
        r.fault = mem_fault;
      end else begin
        if (phase == 0 && dcache_req_valid) begin
          phase = 1; cnt = 0; r.saw_req = 1;
          r.addr = dcache_addr; r.we = dcache_we; r.wdata = dcache_wdata; r.wstrb = dcache_wstrb;
        end
        if (phase == 1) begin
          if (!dcache_req_valid || dcache_addr !== r.addr || dcache_we !== r.we ||
              dcache_wdata !== r.wdata || dcache_wstrb !== r.wstrb) r.stable = 0;
          if (cnt == rdy) dcache_req_ready = 1'b1;
          cnt++;
        end else if (phase >= 2) begin
          if (dcache_req_valid) r.stable = 0;
          if (phase == 2) begin
            if (cnt == rsp) begin
              dcache_resp_valid = 1'b1;
              dcache_rdata      = rd;
            end
            cnt++;
          end
        end
      end
    end
    dcache_req_ready  = 1'b0;
    dcache_resp_valid = 1'b0;
    if (r.got_done) begin
      @(posedge clk); #1;
      r.held = memory_done && (mem_data_out === r.mem) && (alu_data_out === r.alu);
      memory_enable = 1'b0;
      @(posedge clk); #1;
      r.drop = !memory_done;
    end else begin
      memory_enable = 1'b0;
      reset = 1'b0;
      #2;
      reset = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic run_chk(input string nm, input logic [6:0] op, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] rd,
                         input int unsigned rdy, input int unsigned rsp, input exp_t e);
    res_t                  r;
    control_signals_struct c;
    c = mk_ctrl(op, f3);
    do_txn(c, a, b, rd, rdy, rsp, r);
    chk({nm, " done_seen"}, 64'(r.got_done), 64'd1);
    chk({nm, " req_issued"}, 64'(r.saw_req), 64'(e.req));
    if (e.req) begin
      chk({nm, " addr"}, r.addr, a);
      chk({nm, " we"}, 64'(r.we), 64'(e.we));
      chk({nm, " req_stable"}, 64'(r.stable), 64'd1);
      chk({nm, " done_after_resp"}, 64'(r.order), 64'd1);
      chk({nm, " latency"}, 64'(r.cycles), 64'(3 + rdy + rsp));
      if (e.we) begin
        chk({nm, " wdata"}, r.wdata, e.wdata);
        chk({nm, " wstrb"}, 64'(r.wstrb), 64'(e.wstrb));
      end
    end else begin
      chk({nm, " latency"}, 64'(r.cycles), 64'd1);
    end
    chk({nm, " mem_data"}, r.mem, e.mem);
    chk({nm, " alu_out"}, r.alu, a);
    chk({nm, " ctrl_out"}, 64'(r.ctrl), 64'(c));
    chk({nm, " fault"}, 64'(r.fault), 64'(e.fault));
    chk({nm, " done_hold"}, 64'(r.held), 64'd1);
    chk({nm, " done_release"}, 64'(r.drop), 64'd1);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " req_valid"}, 64'(dcache_req_valid), 64'd0);
    chk({nm, " addr"}, dcache_addr, 64'd0);
    chk({nm, " we"}, 64'(dcache_we), 64'd0);
    chk({nm, " wdata"}, dcache_wdata, 64'd0);
    chk({nm, " wstrb"}, 64'(dcache_wstrb), 64'd0);
    chk({nm, " mem_data"}, mem_data_out, 64'd0);
    chk({nm, " alu_out"}, alu_data_out, 64'd0);
    chk({nm, " ctrl_out"}, 64'(control_signals_out), 64'd0);
    chk({nm, " done"}, 64'(memory_done), 64'd0);
    chk({nm, " fault"}, 64'(mem_fault), 64'd0);
  endtask

  vec_t vecs[$];

  task automatic add(input string nm, input logic [6:0] op, input logic [2:0] f3, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] rd, input int unsigned rdy,
                     input int unsigned rsp, input exp_t e);
    vec_t v;
    v.nm = nm; v.op = op; v.f3 = f3; v.a = a; v.b = b; v.rd = rd; v.rdy = rdy; v.rsp = rsp; v.e = e;
    vecs.push_back(v);
  endtask

  initial begin
    reset             = 1'b0;
    alu_data_in       = '0;
    reg_b_contents    = '0;
    control_signals   = '0;
    memory_enable     = 1'b0;
    dcache_req_ready  = 1'b0;
    dcache_resp_valid = 1'b0;
    dcache_rdata      = '0;

    // Directed table
    add("addi",   OP_ALU, 3'd0, 64'h1234, 64'h5, 64'h0, 0, 0, mk_exp(0, 0, '0, '0, '0, 0));
    add("lb",     OP_LD, 3'd0, 64'h1003, 64'h0, 64'h00000000_80000000, 0, 0,
        mk_exp(1, 0, '0, '0, 64'hFFFF_FFFF_FFFF_FF80, 0));
    add("lbu",    OP_LD, 3'd4, 64'h1003, 64'h0, 64'h00000000_80000000, 0, 0,
        mk_exp(1, 0, '0, '0, 64'h80, 0));
    add("sh",     OP_ST, 3'd1, 64'h1006, 64'hBEEF, 64'h0, 5, 3,
        mk_exp(1, 1, 64'hBEEF_0000_0000_0000, 8'hC0, '0, 0));
    add("ld",     OP_LD, 3'd3, 64'h2000, 64'h0, 64'h0123_4567_89AB_CDEF, 1, 2,
        mk_exp(1, 0, '0, '0, 64'h0123_4567_89AB_CDEF, 0));
    add("lw",     OP_LD, 3'd2, 64'h1004, 64'h0, 64'h8000_0001_0000_0000, 0, 1,
        mk_exp(1, 0, '0, '0, 64'hFFFF_FFFF_8000_0001, 0));
    add("lwu",    OP_LD, 3'd6, 64'h1004, 64'h0, 64'h8000_0001_0000_0000, 2, 0,
        mk_exp(1, 0, '0, '0, 64'h0000_0000_8000_0001, 0));
    add("lh",     OP_LD, 3'd1, 64'h1002, 64'h0, 64'h0000_0000_8001_0000, 0, 0,
        mk_exp(1, 0, '0, '0, 64'hFFFF_FFFF_FFFF_8001, 0));
    add("lhu",    OP_LD, 3'd5, 64'h1002, 64'h0, 64'h0000_0000_8001_0000, 0, 0,
        mk_exp(1, 0, '0, '0, 64'h8001, 0));
    add("sd",     OP_ST, 3'd3, 64'h2008, 64'h0123_4567_89AB_CDEF, 64'h0, 0, 0,
        mk_exp(1, 1, 64'h0123_4567_89AB_CDEF, 8'hFF, '0, 0));
    add("sb",     OP_ST, 3'd0, 64'h2005, 64'h1122_3344_5566_77AB, 64'h0, 1, 1,
        mk_exp(1, 1, 64'h6677_AB00_0000_0000, 8'h20, '0, 0));
    add("sw",     OP_ST, 3'd2, 64'h3004, 64'hCAFE_F00D, 64'h0, 0, 0,
        mk_exp(1, 1, 64'hCAFE_F00D_0000_0000, 8'hF0, '0, 0));
    add("ld_ill", OP_LD, 3'd7, 64'h1000, 64'h0, 64'hFFFF, 0, 0, mk_exp(0, 0, '0, '0, '0, 0));
    add("st_ill", OP_ST, 3'd4, 64'h1000, 64'h77, 64'h0, 0, 0, mk_exp(0, 0, '0, '0, '0, 0));
    add("lw_mis", OP_LD, 3'd2, 64'h1002, 64'h0, 64'h1122_3344_5566_7788, 0, 0,
        TRAP ? mk_exp(0, 0, '0, '0, '0, 1) : mk_exp(1, 0, '0, '0, 64'h3344_5566, 0));
    add("sw_mis", OP_ST, 3'd2, 64'h1006, 64'hDEAD_BEEF, 64'h0, 0, 0,
        TRAP ? mk_exp(0, 0, '0, '0, '0, 1) : mk_exp(1, 1, 64'hBEEF_0000_0000_0000, 8'hC0, '0, 0));
    add("sd_mis", OP_ST, 3'd3, 64'h1001, 64'h0102_0304_0506_0708, 64'h0, 0, 0,
        TRAP ? mk_exp(0, 0, '0, '0, '0, 1) : mk_exp(1, 1, 64'h0203_0405_0607_0800, 8'hFE, '0, 0));

    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i])
      run_chk(vecs[i].nm, vecs[i].op, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd,
              vecs[i].rdy, vecs[i].rsp, vecs[i].e);

    // Enable dropped while in REQ; response during REQ must be ignored.
    control_signals = mk_ctrl(OP_ST, 3'd3);
    alu_data_in     = 64'h3000;
    reg_b_contents  = 64'hA5A5_5A5A_0F0F_F0F0;
    memory_enable   = 1'b1;
    @(posedge clk); #1;
    chk("drop req_valid", 64'(dcache_req_valid), 64'd1);
    memory_enable     = 1'b0;
    dcache_resp_valid = 1'b1;
    @(posedge clk); #1;
    chk("drop resp_in_req_ignored", 64'(dcache_req_valid), 64'd1);
    chk("drop no_early_done", 64'(memory_done), 64'd0);
    dcache_resp_valid = 1'b0;
    dcache_req_ready  = 1'b1;
    @(posedge clk); #1;
    dcache_req_ready = 1'b0;
    chk("drop wait_req_low", 64'(dcache_req_valid), 64'd0);
    chk("drop wait_no_done", 64'(memory_done), 64'd0);
    dcache_resp_valid = 1'b1;
    @(posedge clk); #1;
    dcache_resp_valid = 1'b0;
    chk("drop done", 64'(memory_done), 64'd1);
    @(posedge clk); #1;
    chk("drop done_one_cycle", 64'(memory_done), 64'd0);

    // Reset while waiting for the response; late response must be ignored.
    control_signals = mk_ctrl(OP_LD, 3'd3);
    alu_data_in     = 64'h4000;
    memory_enable   = 1'b1;
    @(posedge clk); #1;
    dcache_req_ready = 1'b1;
    @(posedge clk); #1;
    dcache_req_ready = 1'b0;
    chk("rstwait in_wait", 64'(dcache_req_valid), 64'd0);
    memory_enable = 1'b0;
    reset = 1'b0;
    #2;
    chk_all_zero("rstwait async");
    @(posedge clk); #1;
    reset = 1'b1;
    dcache_resp_valid = 1'b1;
    dcache_req_ready  = 1'b1;
    dcache_rdata      = 64'hDEAD_BEEF_DEAD_BEEF;
    repeat (2) @(posedge clk);
    #1;
    dcache_resp_valid = 1'b0;
    dcache_req_ready  = 1'b0;
    chk_all_zero("rstwait late_resp");

    // Randomized against the byte-level model
    for (int n = 0; n < 40; n++) begin
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [63:0] a, b, rd;
      int unsigned kind;
      logic [6:0]  alu_ops [4];
      alu_ops = '{7'b0010011, 7'b0110011, 7'b1101111, 7'b1100011};
      kind = $urandom_range(0, 2);
      op   = (kind == 0) ? alu_ops[$urandom_range(0, 3)] : ((kind == 1) ? OP_LD : OP_ST);
      f3   = 3'($urandom_range(0, 7));
      a    = {$urandom(), $urandom()};
      b    = {$urandom(), $urandom()};
      rd   = {$urandom(), $urandom()};
      run_chk($sformatf("rnd%0d", n), op, f3, a, b, rd, $urandom_range(0, 3), $urandom_range(0, 3),
              model(op, f3, a, b, rd));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
